// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, status/control registers and a level IRQ
// sitting between the data bus and one uart_t/uart_r pair.
module uart_mmio_ctrl #(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        irq
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_CW = RX_AW + 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} tx_state_e;

  tx_state_e state, state_next;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr, tx_rptr;
  logic [TX_CW-1:0] tx_count;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr, rx_rptr;
  logic [RX_CW-1:0] rx_count;

  logic [1:0]  ctrl;
  logic        overrun;
  logic [31:0] rdata_next;
  logic        launch;
  logic [7:0]  tx_head;

  logic rd, wr;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_busy;
  logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop, ovr_set, ovr_clr;
  logic unused_bits;

  assign rd          = bus_sel & ~bus_we;
  assign wr          = bus_sel & bus_we;
  assign tx_empty    = (tx_count == '0);
  assign tx_full     = (tx_count == TX_CW'(TX_DEPTH));
  assign rx_empty    = (rx_count == '0);
  assign rx_full     = (rx_count == RX_CW'(RX_DEPTH));
  assign tx_busy     = (state == SEND);
  assign tx_push_req = wr & (bus_addr[3:2] == 2'd0);
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

  // A byte written into an empty FIFO while idle launches straight from the bus.
  assign tx_head = tx_empty ? bus_wdata[7:0] : tx_mem[tx_rptr];
  assign tx_pop  = launch & ~tx_empty;
  assign tx_push = tx_push_req & (~tx_full | tx_pop) & ~(launch & tx_empty);

  assign rx_pop  = rd & (bus_addr[3:2] == 2'd0) & ~rx_empty;
  assign rx_push = rx_ready & (~rx_full | rx_pop);
  assign ovr_set = rx_ready & rx_full & ~rx_pop;
  assign ovr_clr = wr & (bus_addr[3:2] == 2'd1) & bus_wdata[4];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = SEND;
      SEND:    if (tx_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    launch = 1'b0;
    if (state == IDLE && (!tx_empty || tx_push_req)) launch = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_en <= launch;
      if (launch) tx_data <= tx_head;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= bus_wdata[7:0];
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + TX_CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - TX_CW'(1);
      if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + RX_CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - RX_CW'(1);
    end
  end

  always_comb begin
    rdata_next = '0;
    if (rd) begin
      case (bus_addr[3:2])
        2'd0:    rdata_next = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr]};
        2'd1:    rdata_next = {26'd0, tx_busy, overrun, rx_full, rx_empty, tx_empty, tx_full};
        2'd2:    rdata_next = {30'd0, ctrl};
        default: rdata_next = '0;
      endcase
    end
  end

  // Overrun set takes priority over a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata <= '0;
      bus_ack   <= 1'b0;
      ctrl      <= '0;
      overrun   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      bus_rdata <= rdata_next;
      bus_ack   <= bus_sel;
      if (wr && bus_addr[3:2] == 2'd2) ctrl <= bus_wdata[1:0];
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & ~tx_busy) | overrun;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: directed vector table, hand sequences for FIFO full/overrun
// corners, then random bus/UART traffic against a queue-based reference model.
module tb_uart_mmio_ctrl;

  localparam int TXD = 16;
  localparam int RXD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel, bus_we, tx_ready, rx_ready;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack, tx_en, irq;
  logic [7:0]  tx_data, rx_data;

  uart_mmio_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .tx_en(tx_en),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_ready(rx_ready), .rx_data(rx_data), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_obs[$];
  bit          m_busy, m_ovr;
  bit [1:0]    m_ctrl;
  logic [31:0] m_rdata;
  bit          m_ack, m_txen, m_irq;
  logic [7:0]  m_txdata;

  typedef struct {
    bit          sel, we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    bit          rxr;
    logic [7:0]  rxd;
    bit          txr;
    bit          e_ack;
    logic [31:0] e_rdata;
    bit          e_txen;
    logic [7:0]  e_txdata;
    bit          e_irq;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(bit sel, bit we, logic [3:0] a, logic [31:0] wd, bit rxr,
                              logic [7:0] rxd, bit txr, bit eack, logic [31:0] erd,
                              bit etxen, logic [7:0] etxd, bit eirq);
    vec_t r;
    r.sel = sel; r.we = we; r.addr = a; r.wdata = wd; r.rxr = rxr; r.rxd = rxd; r.txr = txr;
    r.e_ack = eack; r.e_rdata = erd; r.e_txen = etxen; r.e_txdata = etxd; r.e_irq = eirq;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    tx_q.delete(); rx_q.delete(); tx_obs.delete();
    m_busy = 0; m_ovr = 0; m_ctrl = 0;
  endtask

  // Expected registered outputs after the edge that samples these inputs.
  task automatic model_step(bit sel, bit we, logic [3:0] a, logic [31:0] wd, bit rxr,
                            logic [7:0] rxd, bit txr);
    logic [1:0]  r = a[3:2];
    logic [31:0] rdv = 0;
    logic [31:0] status;
    bit launch, set, clr, push;
    status = 0;
    status[0] = (tx_q.size() == TXD);
    status[1] = (tx_q.size() == 0);
    status[2] = (rx_q.size() == 0);
    status[3] = (rx_q.size() == RXD);
    status[4] = m_ovr;
    status[5] = m_busy;
    m_irq = (m_ctrl[0] && rx_q.size() != 0) || (m_ctrl[1] && tx_q.size() == 0 && !m_busy) || m_ovr;
    if (sel && !we) begin
      case (r)
        2'd0: if (rx_q.size() != 0) rdv = {24'd0, rx_q.pop_front()};
        2'd1: rdv = status;
        2'd2: rdv = {30'd0, m_ctrl};
        default: rdv = 0;
      endcase
    end
    push   = sel && we && r == 2'd0;
    launch = !m_busy && (tx_q.size() != 0 || push);
    if (push && (tx_q.size() < TXD || launch)) tx_q.push_back(wd[7:0]);
    if (launch) begin
      m_txen = 1; m_txdata = tx_q.pop_front(); m_busy = 1;
    end else begin
      m_txen = 0;
      if (m_busy && txr) m_busy = 0;
    end
    set = 0;
    if (rxr) begin
      if (rx_q.size() < RXD) rx_q.push_back(rxd);
      else set = 1;
    end
    clr = sel && we && r == 2'd1 && wd[4];
    if (set) m_ovr = 1;
    else if (clr) m_ovr = 0;
    if (sel && we && r == 2'd2) m_ctrl = wd[1:0];
    m_rdata = rdv;
    m_ack = sel;
  endtask

  task automatic drive(bit sel, bit we, logic [3:0] a, logic [31:0] wd, bit rxr,
                       logic [7:0] rxd, bit txr);
    bus_sel = sel; bus_we = we; bus_addr = a; bus_wdata = wd;
    rx_ready = rxr; rx_data = rxd; tx_ready = txr;
    model_step(sel, we, a, wd, rxr, rxd, txr);
    @(posedge clk); #1;
    if (tx_en) tx_obs.push_back(tx_data);
  endtask

  task automatic nop(); drive(0, 0, 4'h0, 0, 0, 8'h00, 0); endtask
  task automatic rd_reg(logic [3:0] a); drive(1, 0, a, 0, 0, 8'h00, 0); endtask
  task automatic wr_reg(logic [3:0] a, logic [31:0] d); drive(1, 1, a, d, 0, 8'h00, 0); endtask

  task automatic do_reset();
    rst = 1; bus_sel = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
    rx_ready = 0; rx_data = 0; tx_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset bus_ack", 32'(bus_ack), 0);
    chk("reset bus_rdata", bus_rdata, 0);
    chk("reset tx_en", 32'(tx_en), 0);
    chk("reset tx_data", 32'(tx_data), 0);
    chk("reset irq", 32'(irq), 0);
    rst = 0;
    model_reset();
  endtask

  initial begin
    // sel we addr wdata rxr rxd txr | ack rdata txen txdata irq
    tbl[0]  = mk(1,0,4'h4,0,     0,8'h00,0, 1,32'h06,0,8'h00,0);
    tbl[1]  = mk(1,1,4'h0,32'h41,0,8'h00,0, 1,0,     1,8'h41,0);
    tbl[2]  = mk(1,1,4'h0,32'h42,0,8'h00,0, 1,0,     0,8'h41,0);
    tbl[3]  = mk(1,0,4'h4,0,     0,8'h00,0, 1,32'h24,0,8'h41,0);
    tbl[4]  = mk(0,0,4'h0,0,     0,8'h00,1, 0,0,     0,8'h41,0);
    tbl[5]  = mk(0,0,4'h0,0,     0,8'h00,0, 0,0,     1,8'h42,0);
    tbl[6]  = mk(0,0,4'h0,0,     0,8'h00,1, 0,0,     0,8'h42,0);
    tbl[7]  = mk(1,0,4'h4,0,     0,8'h00,0, 1,32'h06,0,8'h42,0);
    tbl[8]  = mk(0,0,4'h0,0,     1,8'h55,0, 0,0,     0,8'h42,0);
    tbl[9]  = mk(0,0,4'h0,0,     1,8'hAA,0, 0,0,     0,8'h42,0);
    tbl[10] = mk(1,0,4'h0,0,     0,8'h00,0, 1,32'h55,0,8'h42,0);
    tbl[11] = mk(1,0,4'h0,0,     0,8'h00,0, 1,32'hAA,0,8'h42,0);
    tbl[12] = mk(1,0,4'h0,0,     0,8'h00,0, 1,0,     0,8'h42,0);
    tbl[13] = mk(1,0,4'h4,0,     0,8'h00,0, 1,32'h06,0,8'h42,0);
    tbl[14] = mk(1,1,4'h8,32'h1, 0,8'h00,0, 1,0,     0,8'h42,0);
    tbl[15] = mk(0,0,4'h0,0,     1,8'h33,0, 0,0,     0,8'h42,0);
    tbl[16] = mk(0,0,4'h0,0,     0,8'h00,0, 0,0,     0,8'h42,1);
    tbl[17] = mk(1,0,4'h0,0,     0,8'h00,0, 1,32'h33,0,8'h42,1);
    tbl[18] = mk(0,0,4'h0,0,     0,8'h00,0, 0,0,     0,8'h42,0);
    tbl[19] = mk(1,0,4'h8,0,     0,8'h00,0, 1,32'h1, 0,8'h42,0);
    tbl[20] = mk(1,1,4'h8,32'h2, 0,8'h00,0, 1,0,     0,8'h42,0);
    tbl[21] = mk(0,0,4'h0,0,     0,8'h00,0, 0,0,     0,8'h42,1);
    tbl[22] = mk(1,1,4'h8,32'h0, 0,8'h00,0, 1,0,     0,8'h42,1);
    tbl[23] = mk(0,0,4'h0,0,     0,8'h00,0, 0,0,     0,8'h42,0);
    tbl[24] = mk(1,0,4'hC,0,     0,8'h00,0, 1,0,     0,8'h42,0);
    tbl[25] = mk(1,1,4'hC,32'h3, 0,8'h00,0, 1,0,     0,8'h42,0);
    tbl[26] = mk(1,0,4'h8,0,     0,8'h00,0, 1,0,     0,8'h42,0);

    do_reset();

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rxr, tbl[i].rxd, tbl[i].txr);
      chk($sformatf("vec%0d bus_ack", i), 32'(bus_ack), 32'(tbl[i].e_ack));
      chk($sformatf("vec%0d bus_rdata", i), bus_rdata, tbl[i].e_rdata);
      chk($sformatf("vec%0d tx_en", i), 32'(tx_en), 32'(tbl[i].e_txen));
      chk($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(tbl[i].e_txdata));
      chk($sformatf("vec%0d irq", i), 32'(irq), 32'(tbl[i].e_irq));
    end

    // TX full: 17 accepted (1 launched + 16 buffered), 18th dropped, all drained in order
    tx_obs.delete();
    for (int i = 0; i < 18; i++) wr_reg(4'h0, 32'h10 + i);
    chk("txfull launches", tx_obs.size(), 1);
    rd_reg(4'h4);
    chk("txfull status", bus_rdata, 32'h25);
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 4'h0, 0, 0, 8'h00, 1);
      nop();
      nop();
    end
    chk("txfull launch count", tx_obs.size(), 17);
    for (int i = 0; i < 17 && i < tx_obs.size(); i++)
      chk($sformatf("txfull byte%0d", i), 32'(tx_obs[i]), 32'h10 + i);
    rd_reg(4'h4);
    chk("txdrain status", bus_rdata, 32'h06);

    // RX full and overrun corners
    for (int i = 0; i < 17; i++) drive(0, 0, 4'h0, 0, 1, 8'h60 + 8'(i), 0);
    nop();
    rd_reg(4'h4);
    chk("rxfull status", bus_rdata, 32'h1A);
    chk("rxfull irq", 32'(irq), 1);
    drive(1, 1, 4'h4, 32'h10, 1, 8'h71, 0);
    rd_reg(4'h4);
    chk("ovr set wins", bus_rdata, 32'h1A);
    wr_reg(4'h4, 32'h10);
    rd_reg(4'h4);
    chk("ovr clear", bus_rdata, 32'h0A);
    chk("ovr clear irq", 32'(irq), 0);
    drive(1, 0, 4'h0, 0, 1, 8'h77, 0);
    chk("full pop+push rdata", bus_rdata, 32'h60);
    rd_reg(4'h4);
    chk("full pop+push status", bus_rdata, 32'h0A);
    for (int i = 0; i < 16; i++) begin
      rd_reg(4'h0);
      chk($sformatf("rxdrain%0d", i), bus_rdata, (i < 15) ? 32'h61 + i : 32'h77);
    end
    rd_reg(4'h0);
    chk("rx empty read", bus_rdata, 0);
    rd_reg(4'h4);
    chk("rx empty status", bus_rdata, 32'h06);

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            $urandom(), $urandom_range(0, 3) == 0, 8'($urandom()), $urandom_range(0, 5) == 0);
      chk($sformatf("rnd%0d bus_ack", c), 32'(bus_ack), 32'(m_ack));
      chk($sformatf("rnd%0d bus_rdata", c), bus_rdata, m_rdata);
      chk($sformatf("rnd%0d tx_en", c), 32'(tx_en), 32'(m_txen));
      if (m_txen) chk($sformatf("rnd%0d tx_data", c), 32'(tx_data), 32'(m_txdata));
      chk($sformatf("rnd%0d irq", c), 32'(irq), 32'(m_irq));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
